l1_write_buffer: RTL and testbench
==================================

# l1_write_buffer

Posted-write buffer between the L1 cache's memory-side bus and the memory/bus fabric. Cacheable write-backs from the cache complete into a small FIFO in one cycle; entries drain to memory in the background. Reads bypass older buffered writes to other addresses, and same-word full writes are forwarded. Non-cacheable accesses and flush requests drain the buffer completely first, which preserves ordering.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of 2, ≥2.
- NONCACHE_START_ADDR, 32'h8000_0000: addresses at or above this are non-cacheable and never buffered.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous and active-high.
- cache_bus  generic_bus_if.generic_bus  -  upstream, driven by the L1 cache (addr, wdata, ren, wen, byte_en in; rdata, busy out).
- mem_bus  generic_bus_if.cpu  -  downstream, to memory (addr, wdata, ren, wen, byte_en out; rdata, busy in).
- flush  in  1  level request: drain all entries.
- flush_done  out  1  one-cycle pulse when a flush completes with the buffer empty.

## Operation
- Entry: word address addr[31:2], wdata[31:0], byte_en[3:0], valid. The FIFO uses head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a count of width $clog2(DEPTH)+1.
- Upstream cacheable write, not full: enqueue at the tail. cache_bus.busy=0 in the same cycle.
- Upstream cacheable write, full: busy=1 until count<DEPTH. A pop in the same cycle does not free the slot for that cycle's push; the push is accepted one cycle later.
- Upstream cacheable read, address search runs youngest-first:
  - Youngest matching entry has byte_en=4'hF: forward its data; busy=0 the same cycle; no memory access.
  - Youngest matching entry has partial byte_en: busy=1 until that entry has drained, then the read goes to memory.
  - No match: the read is issued to memory ahead of remaining drains.
- Non-cacheable read or write: busy=1 until the buffer is empty, then passed through unbuffered (PASS state).
- Upstream ren and wen both high is illegal; the block treats it as a write.
- Downstream FSM:
  - IDLE: select, in priority order, PASS (non-cacheable request and empty), READ (cacheable read, no blocking match), DRAIN (count>0).
  - DRAIN: mem_bus.wen=1 with head addr/wdata/byte_en, held stable until mem_bus.busy=0. That cycle pops the head and returns to IDLE. A drain in flight is never aborted.
  - READ: mem_bus.ren=1, addr = upstream addr, until mem_bus.busy=0. That cycle drives cache_bus.rdata = mem_bus.rdata with cache_bus.busy=0, then returns to IDLE.
  - PASS: mirror upstream ren/wen/addr/wdata/byte_en onto mem_bus, and mem rdata/busy back upstream, until mem_bus.busy=0. Then return to IDLE.
- Flush: while flush=1, no new reads are started and DRAIN is selected while count>0. flush_done pulses for one cycle in the first IDLE cycle with count=0 and flush=1. flush_done re-pulses only after flush drops and rises again.

## Timing
- Reset values: mem_bus ren/wen=0, addr/wdata/byte_en=0; cache_bus.busy=1, rdata=0; flush_done=0. All entries invalid, pointers and count 0, FSM in IDLE.
- Reset mid-operation discards all buffered writes and any in-flight memory transaction.
- Write-hit latency is 0 cycles (same-cycle busy=0). Forwarded-read latency is 0 cycles.
- Memory read latency is 1 cycle (IDLE→READ) plus memory wait states.
- Drain throughput is one entry per memory completion plus one IDLE cycle.
- Empty buffer: DRAIN is never entered. Wrap-around: after DEPTH pushes, the tail returns to 0.

## Structure
- Package l1_write_buffer_pkg holds wb_entry_t (packed entry struct) and wb_state_t (IDLE, DRAIN, READ, PASS).
- Sub-module wb_fifo holds the circular storage, pointers, count, full/empty, and the youngest-first match search. Its outputs are match, match_full, and match_data. The top level holds the FSM and bus muxing.

## Test plan
- 4 writes to 0x100, 0x104, 0x108, 0x10C with mem_bus.busy held at 1 → each accepted the same cycle; a 5th write sees busy=1 until the first drain completes.
- Write 0x200=0xDEADBEEF with byte_en=F, then read 0x200 → rdata=0xDEADBEEF the same cycle, and no mem_bus.ren.
- Write 0x300 with byte_en=4'b0011, then read 0x300 → busy until the entry drains; mem_bus.ren observed only after the 0x300 write.
- Two buffered writes, then a write to 0x8000_0004 → both drain in order, then the pass-through write; the pass-through write's busy clears on mem completion.
- 3 entries, then flush pulsed → 3 drains in FIFO order, then a single flush_done pulse with count=0.
- RST asserted mid-DRAIN with 2 entries → mem_bus.wen=0 immediately, count=0, cache_bus.busy=1.

Source files
------------

// File: rtl/l1_write_buffer_pkg.sv
// Shared types for the L1 posted-write buffer: entry layout and downstream FSM states.
package l1_write_buffer_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int WADDR_W = ADDR_W - 2;

    typedef struct packed {
        logic               valid;
        logic [WADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
        logic [BE_W-1:0]    be;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2,
        PASS  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/generic_bus_if.sv
// Simple single-beat memory bus: requester drives addr/wdata/ren/wen/byte_en, responder drives rdata/busy.
interface generic_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ren;
    logic        wen;
    logic        busy;
    logic [3:0]  byte_en;

    modport generic_bus (
        input  addr, wdata, ren, wen, byte_en,
        output rdata, busy
    );

    modport cpu (
        output addr, wdata, ren, wen, byte_en,
        input  rdata, busy
    );
endinterface

// File: rtl/wb_fifo.sv
// Circular store of posted writes with head/tail/count and a youngest-first address match.
// Push is ignored by construction when full; the caller only pops a non-empty buffer.
module wb_fifo
    import l1_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  wb_entry_t          push_entry_i,
    input  logic               pop_i,
    input  logic [WADDR_W-1:0] lookup_addr_i,
    output wb_entry_t          head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               match_o,
    output logic               match_full_o,
    output logic [DATA_W-1:0]  match_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t      mem_q [DEPTH];
    logic [PW-1:0]  head_q, tail_q;
    logic [CW-1:0]  count_q;
    logic [PW-1:0]  idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_entry_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop_i) begin
                mem_q[head_q].valid <= 1'b0;
                head_q              <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[head_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // Walk oldest to youngest so the last hit (the youngest) wins.
    always_comb begin
        match_o      = 1'b0;
        match_full_o = 1'b0;
        match_data_o = '0;
        idx          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (mem_q[idx].valid && (mem_q[idx].addr == lookup_addr_i)) begin
                match_o      = 1'b1;
                match_full_o = (mem_q[idx].be == 4'hF);
                match_data_o = mem_q[idx].data;
            end
        end
    end

endmodule

// File: rtl/l1_write_buffer.sv
// Posted-write buffer between the L1 cache and memory: cacheable writes complete in 0 cycles,
// full-word read hits forward, other reads/non-cacheable/flush wait on the background drain FSM.
module l1_write_buffer
    import l1_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH               = 4,
    parameter logic [31:0] NONCACHE_START_ADDR = 32'h8000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    generic_bus_if.generic_bus cache_bus,
    generic_bus_if.cpu         mem_bus,
    input  logic               flush,
    output logic               flush_done
);

    wb_state_t         state_q, state_d;
    logic              flush_seen_q, flush_seen_d;
    logic              push, pop;
    logic              full, empty, match, match_full;
    logic [DATA_W-1:0] match_data;
    wb_entry_t         head, push_entry;
    logic              up_nc, up_wr, up_rd;

    // ren+wen together is treated as a write.
    assign up_nc = (cache_bus.ren || cache_bus.wen) && (cache_bus.addr >= NONCACHE_START_ADDR);
    assign up_wr = cache_bus.wen && !up_nc;
    assign up_rd = cache_bus.ren && !cache_bus.wen && !up_nc;

    assign push_entry = '{valid: 1'b1, addr: cache_bus.addr[31:2],
                          data: cache_bus.wdata, be: cache_bus.byte_en};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (CLK),
        .rst_i        (RST),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .lookup_addr_i(cache_bus.addr[31:2]),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .match_o      (match),
        .match_full_o (match_full),
        .match_data_o (match_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        flush_seen_d      = flush_seen_q && flush;
        flush_done        = 1'b0;
        push              = 1'b0;
        pop               = 1'b0;
        cache_bus.busy    = 1'b1;
        cache_bus.rdata   = '0;
        mem_bus.ren       = 1'b0;
        mem_bus.wen       = 1'b0;
        mem_bus.addr      = '0;
        mem_bus.wdata     = '0;
        mem_bus.byte_en   = '0;

        // Outputs are held at their reset values while RST is high, whatever upstream drives.
        if (!RST) begin
            // Full is the registered count, so a same-cycle pop never frees the slot.
            if (up_wr && !full) begin
                push           = 1'b1;
                cache_bus.busy = 1'b0;
            end else if (up_rd && match && match_full) begin
                cache_bus.busy  = 1'b0;
                cache_bus.rdata = match_data;
            end

            unique case (state_q)
                IDLE: begin
                    if (flush && empty && !flush_seen_q) begin
                        flush_done   = 1'b1;
                        flush_seen_d = 1'b1;
                    end
                    if (up_nc && empty)                 state_d = PASS;
                    else if (up_rd && !match && !flush) state_d = READ;
                    else if (!empty)                    state_d = DRAIN;
                end
                DRAIN: begin
                    mem_bus.wen     = head.valid;
                    mem_bus.addr    = {head.addr, 2'b00};
                    mem_bus.wdata   = head.data;
                    mem_bus.byte_en = head.be;
                    if (!mem_bus.busy) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                end
                READ: begin
                    mem_bus.ren  = 1'b1;
                    mem_bus.addr = cache_bus.addr;
                    if (!mem_bus.busy) begin
                        cache_bus.busy  = 1'b0;
                        cache_bus.rdata = mem_bus.rdata;
                        state_d         = IDLE;
                    end
                end
                PASS: begin
                    mem_bus.ren     = cache_bus.ren;
                    mem_bus.wen     = cache_bus.wen;
                    mem_bus.addr    = cache_bus.addr;
                    mem_bus.wdata   = cache_bus.wdata;
                    mem_bus.byte_en = cache_bus.byte_en;
                    cache_bus.busy  = mem_bus.busy;
                    cache_bus.rdata = mem_bus.rdata;
                    if (!mem_bus.busy) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_write_buffer.sv
// Directed bench for l1_write_buffer: cycle-by-cycle vector table plus hand sequences for full, flush and reset.
module tb_l1_write_buffer;

    logic clk;
    logic rst;
    logic flush;
    logic flush_done;
    int   total = 0;
    int   bad   = 0;

    generic_bus_if cache_if();
    generic_bus_if mem_if();

    l1_write_buffer #(.DEPTH(4), .NONCACHE_START_ADDR(32'h8000_0000)) dut (
        .CLK       (clk),
        .RST       (rst),
        .cache_bus (cache_if),
        .mem_bus   (mem_if),
        .flush     (flush),
        .flush_done(flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w, r;
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic        mb;
        logic [31:0] mrd;
        logic        cb;
        logic [31:0] crd;
        logic        mw, mr;
        logic [31:0] ma, mwd;
        logic [3:0]  mbe;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mkv(logic w, logic r, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                                 logic mb, logic [31:0] mrd, logic cb, logic [31:0] crd,
                                 logic mw, logic mr, logic [31:0] ma, logic [31:0] mwd, logic [3:0] mbe);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.wd = wd; v.be = be; v.mb = mb; v.mrd = mrd;
        v.cb = cb; v.crd = crd; v.mw = mw; v.mr = mr; v.ma = ma; v.mwd = mwd; v.mbe = mbe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        cache_if.wen     = w;
        cache_if.ren     = r;
        cache_if.addr    = a;
        cache_if.wdata   = wd;
        cache_if.byte_en = be;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr [5];
        int k, pulses, pulse_cyc, last_drain, mw_seen;

        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.busy  = 1'b1;
        mem_if.rdata = 32'h0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst mem_wen",    32'(mem_if.wen), 32'd0);
        check("rst mem_ren",    32'(mem_if.ren), 32'd0);
        check("rst mem_addr",   mem_if.addr, 32'h0);
        check("rst mem_wdata",  mem_if.wdata, 32'h0);
        check("rst mem_be",     32'(mem_if.byte_en), 32'h0);
        check("rst cache_busy", 32'(cache_if.busy), 32'd1);
        check("rst cache_rdata", cache_if.rdata, 32'h0);
        check("rst flush_done", 32'(flush_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        //            w  r  addr          wdata         be    mb mrdata        | cb crdata        mw mr maddr         mwdata        mbe
        vecs[0]  = mkv(0, 0, 32'h0,        32'h0,        4'h0, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[1]  = mkv(1, 0, 32'h200,      32'hDEADBEEF, 4'hF, 1, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[2]  = mkv(0, 1, 32'h200,      32'h0,        4'hF, 1, 32'h0,        0, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[3]  = mkv(0, 0, 32'h0,        32'h0,        4'h0, 1, 32'h0,        1, 32'h0,        1, 0, 32'h200,      32'hDEADBEEF, 4'hF);
        vecs[4]  = mkv(0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 32'h0,        1, 0, 32'h200,      32'hDEADBEEF, 4'hF);
        vecs[5]  = mkv(1, 0, 32'h300,      32'h11112222, 4'h3, 1, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[6]  = mkv(0, 1, 32'h300,      32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[7]  = mkv(0, 1, 32'h300,      32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        1, 0, 32'h300,      32'h11112222, 4'h3);
        vecs[8]  = mkv(0, 1, 32'h300,      32'h0,        4'hF, 0, 32'hAAAA5555, 1, 32'h0,        1, 0, 32'h300,      32'h11112222, 4'h3);
        vecs[9]  = mkv(0, 1, 32'h300,      32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[10] = mkv(0, 1, 32'h300,      32'h0,        4'hF, 0, 32'h12345678, 0, 32'h12345678, 0, 1, 32'h300,      32'h0,        4'h0);
        vecs[11] = mkv(0, 1, 32'h400,      32'h0,        4'hF, 0, 32'h0BADF00D, 1, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[12] = mkv(0, 1, 32'h400,      32'h0,        4'hF, 0, 32'h0BADF00D, 0, 32'h0BADF00D, 0, 1, 32'h400,      32'h0,        4'h0);
        vecs[13] = mkv(1, 0, 32'h500,      32'h55,       4'hF, 1, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[14] = mkv(1, 0, 32'h504,      32'h66,       4'hF, 1, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[15] = mkv(1, 0, 32'h80000004, 32'h77,       4'hF, 1, 32'h0,        1, 32'h0,        1, 0, 32'h500,      32'h55,       4'hF);
        vecs[16] = mkv(1, 0, 32'h80000004, 32'h77,       4'hF, 0, 32'h0,        1, 32'h0,        1, 0, 32'h500,      32'h55,       4'hF);
        vecs[17] = mkv(1, 0, 32'h80000004, 32'h77,       4'hF, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[18] = mkv(1, 0, 32'h80000004, 32'h77,       4'hF, 0, 32'h0,        1, 32'h0,        1, 0, 32'h504,      32'h66,       4'hF);
        vecs[19] = mkv(1, 0, 32'h80000004, 32'h77,       4'hF, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);
        vecs[20] = mkv(1, 0, 32'h80000004, 32'h77,       4'hF, 1, 32'h0,        1, 32'h0,        1, 0, 32'h80000004, 32'h77,       4'hF);
        vecs[21] = mkv(1, 0, 32'h80000004, 32'h77,       4'hF, 0, 32'hCAFE0001, 0, 32'hCAFE0001, 1, 0, 32'h80000004, 32'h77,       4'hF);
        vecs[22] = mkv(0, 0, 32'h0,        32'h0,        4'h0, 1, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].wd, vecs[i].be);
            mem_if.busy  = vecs[i].mb;
            mem_if.rdata = vecs[i].mrd;
            @(negedge clk);
            check($sformatf("v%0d cache_busy", i),  32'(cache_if.busy), 32'(vecs[i].cb));
            check($sformatf("v%0d cache_rdata", i), cache_if.rdata, vecs[i].crd);
            check($sformatf("v%0d mem_wen", i),     32'(mem_if.wen), 32'(vecs[i].mw));
            check($sformatf("v%0d mem_ren", i),     32'(mem_if.ren), 32'(vecs[i].mr));
            check($sformatf("v%0d mem_addr", i),    mem_if.addr, vecs[i].ma);
            check($sformatf("v%0d mem_wdata", i),   mem_if.wdata, vecs[i].mwd);
            check($sformatf("v%0d mem_be", i),      32'(mem_if.byte_en), 32'(vecs[i].mbe));
            next_cycle();
        end

        // Fill to DEPTH with memory stalled; a fifth write waits for the first drain.
        mem_if.busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
            @(negedge clk);
            check($sformatf("fill%0d busy", i), 32'(cache_if.busy), 32'd0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'h110, 32'hA4, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("full%0d busy", i), 32'(cache_if.busy), 32'd1);
            next_cycle();
        end
        mem_if.busy = 1'b0;
        @(negedge clk);
        check("pop-cycle busy", 32'(cache_if.busy), 32'd1);
        check("pop-cycle addr", mem_if.addr, 32'h100);
        next_cycle();
        @(negedge clk);
        check("after-pop busy", 32'(cache_if.busy), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_addr[0] = 32'h104; exp_addr[1] = 32'h108; exp_addr[2] = 32'h10C; exp_addr[3] = 32'h110;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_if.wen && !mem_if.busy) begin
                if (k < 4) check($sformatf("drain%0d addr", k), mem_if.addr, exp_addr[k]);
                k++;
            end
            next_cycle();
        end
        check("drain count", 32'(k), 32'd4);

        // Flush with three entries.
        mem_if.busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h600 + 32'(4 * i), 32'(i + 1), 4'hF);
            @(negedge clk);
            check($sformatf("fw%0d busy", i), 32'(cache_if.busy), 32'd0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        flush = 1'b1;
        mem_if.busy = 1'b0;
        exp_addr[0] = 32'h600; exp_addr[1] = 32'h604; exp_addr[2] = 32'h608;
        k = 0; pulses = 0; pulse_cyc = -1; last_drain = 100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_if.wen && !mem_if.busy) begin
                if (k < 3) check($sformatf("fdrain%0d addr", k), mem_if.addr, exp_addr[k]);
                k++;
                last_drain = c;
            end
            if (flush_done) begin
                pulses++;
                pulse_cyc = c;
            end
            next_cycle();
        end
        check("flush drains", 32'(k), 32'd3);
        check("flush pulses", 32'(pulses), 32'd1);
        check("flush after drains", 32'(pulse_cyc > last_drain), 32'd1);
        flush = 1'b0;
        @(negedge clk);
        check("flush low done", 32'(flush_done), 32'd0);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("reflush done", 32'(flush_done), 32'd1);
        next_cycle();
        @(negedge clk);
        check("reflush single", 32'(flush_done), 32'd0);
        next_cycle();
        flush = 1'b0;

        // Reset in the middle of a drain with two entries.
        mem_if.busy = 1'b1;
        drive(1'b1, 1'b0, 32'h700, 32'h7, 4'hF);
        next_cycle();
        drive(1'b1, 1'b0, 32'h704, 32'h8, 4'hF);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("pre-rst mem_wen", 32'(mem_if.wen), 32'd1);
        check("pre-rst addr", mem_if.addr, 32'h700);
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h708, 32'h9, 4'hF);
        #1;
        check("mid-rst mem_wen", 32'(mem_if.wen), 32'd0);
        check("mid-rst cache_busy", 32'(cache_if.busy), 32'd1);
        check("mid-rst count", 32'(dut.u_fifo.count_q), 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.busy = 1'b0;
        mw_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_if.wen) mw_seen++;
            next_cycle();
        end
        check("post-rst drains", 32'(mw_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
